// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and helpers for the modulo-M counter
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Width needed to hold 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/counter_mod_m_next.sv
// rtl/counter_mod_m_next.sv - combinational next-state and flag logic for counter_mod_m
module counter_mod_m_next
  import counter_pkg::*;
#(
  parameter int M        = 5,
  parameter int W        = clog2_min1(M),
  parameter int SATURATE = 0
) (
  input  logic [W-1:0] qout,
  input  logic         en,
  input  logic         up_dn,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] qout_nxt,
  output logic         wrap_nxt,
  output logic         load_err_nxt
);

  localparam logic [W-1:0] MAX = W'(M - 1);

  always_comb begin
    qout_nxt     = qout;
    wrap_nxt     = 1'b0;
    load_err_nxt = 1'b0;
    if (clr) begin
      qout_nxt = '0;
    end else if (load) begin
      if (load_val > MAX) begin
        qout_nxt     = MAX;
        load_err_nxt = 1'b1;
      end else begin
        qout_nxt = load_val;
      end
    end else if (en) begin
      // Out-of-range states recover to the first legal value in the count direction.
      if (up_dn == DIR_UP) begin
        if (qout > MAX) begin
          qout_nxt = '0;
        end else if (qout == MAX) begin
          if (SATURATE == 0) begin
            qout_nxt = '0;
            wrap_nxt = 1'b1;
          end
        end else begin
          qout_nxt = qout + 1'b1;
        end
      end else begin
        if (qout > MAX) begin
          qout_nxt = MAX;
        end else if (qout == '0) begin
          if (SATURATE == 0) begin
            qout_nxt = MAX;
            wrap_nxt = 1'b1;
          end
        end else begin
          qout_nxt = qout - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/counter_mod_m.sv
// rtl/counter_mod_m.sv - cascadable up/down modulo-M counter with clear, preload and saturation
module counter_mod_m
  import counter_pkg::*;
#(
  parameter int M         = 5,
  parameter int W         = clog2_min1(M),
  parameter int SATURATE  = 0,
  parameter int RESET_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up_dn,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] qout,
  output logic         z,
  output logic         carry_out,
  output logic         wrap,
  output logic         load_err
);

  localparam logic [W-1:0] MAX = W'(M - 1);

  if (M < 2 || RESET_VAL < 0 || RESET_VAL >= M) begin : g_bad_param
    $error("counter_mod_m: need M >= 2 and 0 <= RESET_VAL < M");
  end

  logic [W-1:0] qout_d, qout_q;
  logic         wrap_d, wrap_q;
  logic         load_err_d, load_err_q;

  counter_mod_m_next #(
    .M        (M),
    .W        (W),
    .SATURATE (SATURATE)
  ) u_next (
    .qout         (qout_q),
    .en           (en),
    .up_dn        (up_dn),
    .clr          (clr),
    .load         (load),
    .load_val     (load_val),
    .qout_nxt     (qout_d),
    .wrap_nxt     (wrap_d),
    .load_err_nxt (load_err_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qout_q     <= W'(RESET_VAL);
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      qout_q     <= qout_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  // Terminal count follows up_dn combinationally so a cascade sees a direction flip at once.
  assign z         = (up_dn == DIR_UP) ? (qout_q == MAX) : (qout_q == '0);
  assign carry_out = z & en;
  assign qout      = qout_q;
  assign wrap      = wrap_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_counter_mod_m.sv
// tb/tb_counter_mod_m.sv - directed self-checking bench for counter_mod_m
module tb_counter_mod_m;

  logic clk;
  int total;
  int bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // M=5 wrapping instance
  logic       a_rst, a_en, a_up, a_clr, a_load;
  logic [2:0] a_lv, a_q;
  logic       a_z, a_co, a_wrap, a_lerr;

  // M=5 saturating instance
  logic       s_rst, s_en, s_up, s_clr, s_load;
  logic [2:0] s_lv, s_q;
  logic       s_z, s_co, s_wrap, s_lerr;

  // M=10 cascade
  logic       c_rst, c_en;
  logic [3:0] lo_q, hi_q;
  logic       lo_z, lo_co, lo_wrap, lo_lerr;
  logic       hi_z, hi_co, hi_wrap, hi_lerr;

  // M=8 power-of-two instance
  logic       p_rst, p_en, p_up, p_clr, p_load;
  logic [2:0] p_lv, p_q;
  logic       p_z, p_co, p_wrap, p_lerr;

  counter_mod_m #(.M(5)) u_a (
    .clk(clk), .rst(a_rst), .en(a_en), .up_dn(a_up), .clr(a_clr), .load(a_load),
    .load_val(a_lv), .qout(a_q), .z(a_z), .carry_out(a_co), .wrap(a_wrap), .load_err(a_lerr)
  );

  counter_mod_m #(.M(5), .SATURATE(1)) u_s (
    .clk(clk), .rst(s_rst), .en(s_en), .up_dn(s_up), .clr(s_clr), .load(s_load),
    .load_val(s_lv), .qout(s_q), .z(s_z), .carry_out(s_co), .wrap(s_wrap), .load_err(s_lerr)
  );

  counter_mod_m #(.M(10)) u_lo (
    .clk(clk), .rst(c_rst), .en(c_en), .up_dn(1'b1), .clr(1'b0), .load(1'b0),
    .load_val(4'd0), .qout(lo_q), .z(lo_z), .carry_out(lo_co), .wrap(lo_wrap), .load_err(lo_lerr)
  );

  counter_mod_m #(.M(10)) u_hi (
    .clk(clk), .rst(c_rst), .en(lo_co), .up_dn(1'b1), .clr(1'b0), .load(1'b0),
    .load_val(4'd0), .qout(hi_q), .z(hi_z), .carry_out(hi_co), .wrap(hi_wrap), .load_err(hi_lerr)
  );

  counter_mod_m #(.M(8)) u_p (
    .clk(clk), .rst(p_rst), .en(p_en), .up_dn(p_up), .clr(p_clr), .load(p_load),
    .load_val(p_lv), .qout(p_q), .z(p_z), .carry_out(p_co), .wrap(p_wrap), .load_err(p_lerr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; s_rst = 1'b1; c_rst = 1'b1; p_rst = 1'b1;
    step();
    step();
    total++; if (a_q !== 3'd0) begin bad++; $display("FAIL reset_q got=%0d exp=0", a_q); end
    total++; if (a_wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b exp=0", a_wrap); end
    total++; if (a_lerr !== 1'b0) begin bad++; $display("FAIL reset_lerr got=%b exp=0", a_lerr); end
    total++; if ({hi_q, lo_q} !== 8'h00) begin bad++; $display("FAIL reset_cascade got=%h exp=00", {hi_q, lo_q}); end
    a_rst = 1'b0; s_rst = 1'b0; c_rst = 1'b0; p_rst = 1'b0;
  endtask

  task automatic test_wrap_up();
    logic [2:0] exp_q [12] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2};
    logic [2:0] prev;
    prev = 3'd0;
    a_en = 1'b1; a_up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      total++; if (a_z !== (prev == 3'd4)) begin bad++; $display("FAIL up_z[%0d] got=%b exp=%b", i, a_z, prev == 3'd4); end
      total++; if (a_co !== (prev == 3'd4)) begin bad++; $display("FAIL up_carry[%0d] got=%b exp=%b", i, a_co, prev == 3'd4); end
      step();
      total++; if (a_q !== exp_q[i]) begin bad++; $display("FAIL up_q[%0d] got=%0d exp=%0d", i, a_q, exp_q[i]); end
      total++; if (a_wrap !== (prev == 3'd4)) begin bad++; $display("FAIL up_wrap[%0d] got=%b exp=%b", i, a_wrap, prev == 3'd4); end
      prev = exp_q[i];
    end
  endtask

  task automatic test_down();
    logic [2:0] exp_q [6] = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd4};
    logic       exp_w [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    total++; if (a_q !== 3'd0) begin bad++; $display("FAIL down_clr got=%0d exp=0", a_q); end
    a_up = 1'b0;
    #1;
    total++; if (a_z !== 1'b1) begin bad++; $display("FAIL down_z_at0 got=%b exp=1", a_z); end
    for (int i = 0; i < 6; i++) begin
      step();
      total++; if (a_q !== exp_q[i]) begin bad++; $display("FAIL down_q[%0d] got=%0d exp=%0d", i, a_q, exp_q[i]); end
      total++; if (a_wrap !== exp_w[i]) begin bad++; $display("FAIL down_wrap[%0d] got=%b exp=%b", i, a_wrap, exp_w[i]); end
    end
    step();
    step();
    total++; if (a_q !== 3'd2) begin bad++; $display("FAIL down_to2 got=%0d exp=2", a_q); end
    a_up = 1'b1;
    step();
    total++; if (a_q !== 3'd3) begin bad++; $display("FAIL flip_dir got=%0d exp=3", a_q); end
  endtask

  task automatic test_load_priority();
    a_en = 1'b0; a_load = 1'b1; a_lv = 3'd3;
    step();
    total++; if (a_q !== 3'd3) begin bad++; $display("FAIL load3_q got=%0d exp=3", a_q); end
    total++; if (a_lerr !== 1'b0) begin bad++; $display("FAIL load3_err got=%b exp=0", a_lerr); end
    a_lv = 3'd7;
    step();
    total++; if (a_q !== 3'd4) begin bad++; $display("FAIL load7_q got=%0d exp=4", a_q); end
    total++; if (a_lerr !== 1'b1) begin bad++; $display("FAIL load7_err got=%b exp=1", a_lerr); end
    a_load = 1'b0;
    step();
    total++; if (a_lerr !== 1'b0) begin bad++; $display("FAIL lerr_pulse got=%b exp=0", a_lerr); end
    total++; if (a_q !== 3'd4) begin bad++; $display("FAIL hold_q got=%0d exp=4", a_q); end
    a_load = 1'b1; a_lv = 3'd2; a_en = 1'b1; a_up = 1'b1;
    step();
    total++; if (a_q !== 3'd2) begin bad++; $display("FAIL load_over_en got=%0d exp=2", a_q); end
    a_lv = 3'd4;
    step();
    a_clr = 1'b1; a_lv = 3'd7;
    step();
    total++; if (a_q !== 3'd0) begin bad++; $display("FAIL clr_prio_q got=%0d exp=0", a_q); end
    total++; if (a_lerr !== 1'b0) begin bad++; $display("FAIL clr_prio_lerr got=%b exp=0", a_lerr); end
    total++; if (a_wrap !== 1'b0) begin bad++; $display("FAIL clr_prio_wrap got=%b exp=0", a_wrap); end
    a_clr = 1'b0; a_load = 1'b0; a_en = 1'b0;
  endtask

  task automatic test_saturate();
    logic [2:0] exp_q [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4};
    s_en = 1'b1; s_up = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      total++; if (s_q !== exp_q[i]) begin bad++; $display("FAIL sat_up_q[%0d] got=%0d exp=%0d", i, s_q, exp_q[i]); end
      total++; if (s_wrap !== 1'b0) begin bad++; $display("FAIL sat_up_wrap[%0d] got=%b exp=0", i, s_wrap); end
    end
    total++; if (s_z !== 1'b1) begin bad++; $display("FAIL sat_z got=%b exp=1", s_z); end
    s_clr = 1'b1;
    step();
    s_clr = 1'b0; s_up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (s_q !== 3'd0) begin bad++; $display("FAIL sat_dn_q[%0d] got=%0d exp=0", i, s_q); end
      total++; if (s_wrap !== 1'b0) begin bad++; $display("FAIL sat_dn_wrap[%0d] got=%b exp=0", i, s_wrap); end
    end
    s_en = 1'b0;
  endtask

  task automatic test_cascade();
    c_en = 1'b1;
    for (int i = 0; i < 37; i++) step();
    total++; if ({hi_q, lo_q} !== 8'h37) begin bad++; $display("FAIL casc37 got=%h exp=37", {hi_q, lo_q}); end
    for (int i = 0; i < 62; i++) step();
    total++; if ({hi_q, lo_q} !== 8'h99) begin bad++; $display("FAIL casc99 got=%h exp=99", {hi_q, lo_q}); end
    total++; if (lo_co !== 1'b1 || hi_co !== 1'b1) begin bad++; $display("FAIL casc99_co got=%b%b exp=11", hi_co, lo_co); end
    step();
    total++; if ({hi_q, lo_q} !== 8'h00) begin bad++; $display("FAIL casc00 got=%h exp=00", {hi_q, lo_q}); end
    total++; if (lo_wrap !== 1'b1 || hi_wrap !== 1'b1) begin bad++; $display("FAIL casc_wrap got=%b%b exp=11", hi_wrap, lo_wrap); end
    c_en = 1'b0;
  endtask

  task automatic test_pow2_async();
    p_en = 1'b1; p_up = 1'b1;
    for (int i = 0; i < 7; i++) step();
    total++; if (p_q !== 3'd7) begin bad++; $display("FAIL p2_at7 got=%0d exp=7", p_q); end
    total++; if (p_z !== 1'b1) begin bad++; $display("FAIL p2_z got=%b exp=1", p_z); end
    step();
    total++; if (p_q !== 3'd0) begin bad++; $display("FAIL p2_wrapq got=%0d exp=0", p_q); end
    total++; if (p_wrap !== 1'b1) begin bad++; $display("FAIL p2_wrap got=%b exp=1", p_wrap); end
    for (int i = 0; i < 5; i++) step();
    total++; if (p_q !== 3'd5) begin bad++; $display("FAIL p2_at5 got=%0d exp=5", p_q); end
    #2;
    p_rst = 1'b1;
    #1;
    total++; if (p_q !== 3'd0) begin bad++; $display("FAIL async_rst got=%0d exp=0", p_q); end
    #1;
    p_rst = 1'b0;
    step();
    total++; if (p_q !== 3'd1) begin bad++; $display("FAIL resume got=%0d exp=1", p_q); end
    total++; if (p_wrap !== 1'b0) begin bad++; $display("FAIL resume_wrap got=%b exp=0", p_wrap); end
    p_en = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    a_rst = 1'b0; a_en = 1'b0; a_up = 1'b1; a_clr = 1'b0; a_load = 1'b0; a_lv = 3'd0;
    s_rst = 1'b0; s_en = 1'b0; s_up = 1'b1; s_clr = 1'b0; s_load = 1'b0; s_lv = 3'd0;
    c_rst = 1'b0; c_en = 1'b0;
    p_rst = 1'b0; p_en = 1'b0; p_up = 1'b1; p_clr = 1'b0; p_load = 1'b0; p_lv = 3'd0;
    #2;
    test_reset();
    test_wrap_up();
    test_down();
    test_load_priority();
    test_saturate();
    test_cascade();
    test_pow2_async();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
